mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit-address / 8-bit-data memory port between NUM_REQ requesters, for example the CPU, a DMA engine and an I/O bridge.
- Round-robin grant, one transaction in flight at a time.
- Drives the memory's mem_read/mem_write/address/data_in and returns read data to the granted requester.
- Sits between the requesters and memory inside motherboard.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 16: address width.
- DATA_W, 8: data width.
- ROM_BASE, 256: first ROM address; addresses >= ROM_BASE are read-only.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- req_valid  in  NUM_REQ: per-requester request valid.
- req_write  in  NUM_REQ: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W: packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W: packed write data.
- req_ready  out  NUM_REQ: one-hot accept pulse.
- rsp_valid  out  NUM_REQ: one-hot read-data-valid pulse.
- rsp_rdata  out  DATA_W: read data, shared by all requesters.
- mem_address  out  ADDR_W: to memory address.
- mem_wdata  out  DATA_W: to memory data_in.
- mem_read  out  1: to memory mem_read.
- mem_write  out  1: to memory mem_write.
- mem_rdata  in  DATA_W: from memory data_out.
- busy  out  1: state != IDLE.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - rr_ptr = NUM_REQ-1, so requester 0 wins first.
- Request handshake:
  - A request completes when req_valid[i] & req_ready[i] at posedge clk.
  - Requester holds valid, write, addr and wdata stable until accepted.
  - req_ready is combinational: asserted only in IDLE, only for the granted index, only while its req_valid is high.
- Grant:
  - Search starts at rr_ptr+1 mod NUM_REQ; first valid requester wins.
  - On accept, rr_ptr <= granted index.
  - Requests not granted wait; no starvation. Every valid requester is granted within NUM_REQ transactions.
- Accept captures grant index, write flag, address and data into registers.
- State machine:
  - IDLE: on accept, go to ISSUE; otherwise stay.
  - ISSUE:
    - mem_address and mem_wdata come from the registers.
    - Read: mem_read=1 for exactly this cycle, then go to WAIT.
    - Write: mem_write=1 for exactly this cycle, then go to IDLE.
  - WAIT: memory registers data_out at the ISSUE edge; go to RESP.
  - RESP: rsp_rdata <= mem_rdata, registered on entry to RESP. rsp_valid[grant]=1 for one cycle. Go to IDLE.
- Latency, with accept at edge t:
  - Read: mem_read high in cycle t+1; rsp_valid high in cycle t+3. Back-to-back reads take 4 cycles each.
  - Write: mem_write high in cycle t+1; next accept possible at edge t+2.
- mem_read and mem_write are never high together, and are 0 outside ISSUE.
- mem_address holds its last value outside ISSUE.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,...,NUM_REQ-1,0.
  - A requester dropping valid while not granted is legal; it is simply skipped.
- Address wrap: addresses are passed through unmodified; no range check beyond ROM_BASE.
- Reset mid-operation:
  - Any in-flight transaction is abandoned.
  - No rsp_valid is issued for it.
  - mem_read and mem_write go to 0 on the reset edge.

Optional Feature:
- Macro: MEM_ARB_ROM_GUARD_EN.
- Defined:
  - A write with captured address >= ROM_BASE still passes through ISSUE, but mem_write stays 0.
  - Extra output port rom_wr_err (1 bit) pulses for that ISSUE cycle.
  - Extra output rom_wr_err_cnt (8 bits, saturating) counts such writes; reset value 0.
- Undefined:
  - The rom_wr_err and rom_wr_err_cnt ports do not exist.
  - ROM writes drive mem_write=1 unchanged; memory ignores them.

Decomposition:
- Package mem_bus_pkg:
  - ADDR_W and DATA_W defaults;
  - ROM_BASE default;
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
- Sub-module rr_arbiter: parameter N. Inputs req[N] and ptr. Outputs gnt one-hot and gnt_idx. Purely combinational rotate / priority-encode / unrotate, reused by future bus masters.
- The FSM, capture registers and optional ROM guard live in mem_bus_arbiter.

Test Plan:
1. Reset, then requester 0 reads address 0x0000 where RAM[0]=0x5A:
   - req_ready[0] in accept cycle;
   - mem_read in the next cycle only;
   - rsp_valid[0]=1 with rsp_rdata=0x5A in the 3rd cycle after accept.
2. Requester 1 writes 0x3C to 0x0010, then reads 0x0010:
   - mem_write one cycle with mem_address=0x0010 and mem_wdata=0x3C;
   - read returns 0x3C on rsp_valid[1] only.
3. Both requesters hold valid reads continuously for 8 transactions:
   - grants alternate 0,1,0,1...;
   - mem_read and mem_write are never both 1;
   - rsp_valid is never 2 bits hot.
4. Reset asserted in WAIT of a read from 0x0001:
   - next cycle state IDLE, busy=0;
   - no rsp_valid pulse;
   - a subsequent request is accepted normally, with requester 0 getting priority.
5. Requester 0 writes 0xFF to 0x0100:
   - with MEM_ARB_ROM_GUARD_EN: mem_write stays 0, rom_wr_err pulses, rom_wr_err_cnt goes 0 to 1;
   - without the macro: mem_write=1 for one cycle.
6. Requester 1 valid alone while rr_ptr=1: granted immediately in the same IDLE cycle; no idle bubble before accept.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory-bus arbiter slice: default widths, the
// first read-only (ROM) address and the arbiter FSM state type.
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 8;
  localparam int ROM_BASE_DEF = 256;
  localparam int ERR_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The request vector is rotated so
// that index ptr+1 lands at position 0. The lowest set bit is then chosen, and
// its position is mapped back to the original index.
//
// Ports:
//   req     in  N         request vector
//   ptr     in  clog2(N)  index of the last winner; search starts at ptr+1
//   gnt     out N         one-hot grant (all zero when no request)
//   gnt_idx out clog2(N)  binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic found;

  always_comb begin
    int src;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Rotated position k corresponds to original index (ptr + 1 + k) mod N.
      // Two subtractions cover ptr values that do not fit a non-power-of-2 N.
      src = int'(ptr) + 1 + k;
      if (src >= N) src = src - N;
      if (src >= N) src = src - N;
      if (!found && req[src]) begin
        found    = 1'b1;
        gnt[src] = 1'b1;
        gnt_idx  = IDX_W'(src);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory port between NUM_REQ requesters. Grants are issued
// round-robin, and only one transaction is in flight at a time.
// Read:  accept -> ISSUE (mem_read) -> WAIT -> RESP (rsp_valid, rsp_rdata).
// Write: accept -> ISSUE (mem_write) -> IDLE.
//
// Optional feature, macro MEM_ARB_ROM_GUARD_EN:
//   A write whose address is >= ROM_BASE still passes through ISSUE, but
//   mem_write is suppressed. rom_wr_err pulses for that cycle, and
//   rom_wr_err_cnt counts the event, saturating at 255.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid/req_write  per-requester valid and write flag
//   req_addr/req_wdata   packed per-requester address and write data
//   req_ready            one-hot accept (combinational, IDLE only)
//   rsp_valid            one-hot read-data-valid pulse
//   rsp_rdata            read data, shared by all requesters
//   mem_address/mem_wdata/mem_read/mem_write/mem_rdata  memory side
//   busy                 FSM not in IDLE
//   rom_wr_err, rom_wr_err_cnt  (MEM_ARB_ROM_GUARD_EN only)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ROM_BASE = ROM_BASE_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_read,
  output logic                      mem_write,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
`ifdef MEM_ARB_ROM_GUARD_EN
  ,
  output logic                      rom_wr_err,
  output logic [ERR_CNT_W-1:0]      rom_wr_err_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mem_bus_arbiter: NUM_REQ must be in 2..8");
  end
  if (ROM_BASE < 0 || 64'(ROM_BASE) > (64'd1 << ADDR_W)) begin : g_bad_rom_base
    $error("mem_bus_arbiter: ROM_BASE outside the address space");
  end

  arb_state_t         state, state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;

  logic [IDX_W-1:0]   cap_idx;
  logic               cap_write;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // gnt is already a subset of req_valid, so no extra masking is needed.
  assign req_ready = (state == IDLE && !reset) ? gnt : '0;
  assign accept    = |req_ready;

  // The captured registers drive the memory port directly. They change only on
  // accept, so the address and data hold their last value outside ISSUE.
  assign mem_address = cap_addr;
  assign mem_wdata   = cap_wdata;
  assign busy        = (state != IDLE);

`ifdef MEM_ARB_ROM_GUARD_EN
  logic rom_hit;
  assign rom_hit = (cap_addr >= ADDR_W'(ROM_BASE));
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    rsp_valid  = '0;
`ifdef MEM_ARB_ROM_GUARD_EN
    rom_wr_err = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        if (cap_write) begin
`ifdef MEM_ARB_ROM_GUARD_EN
          mem_write  = !rom_hit;
          rom_wr_err = rom_hit;
`else
          mem_write  = 1'b1;
`endif
          state_next = IDLE;
        end else begin
          mem_read   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = {{(NUM_REQ-1){1'b0}}, 1'b1} << cap_idx;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the winning request at accept and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the capture registers are reset too, because they drive mem_address/mem_wdata directly.
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      rr_ptr    <= gnt_idx;
      cap_idx   <= gnt_idx;
      cap_write <= req_write[gnt_idx];
      cap_addr  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
      cap_wdata <= req_wdata[gnt_idx*DATA_W +: DATA_W];
    end
  end

  // The memory registers data_out at the ISSUE edge, so it is valid during WAIT.
  always_ff @(posedge clk) begin
    if (reset)              rsp_rdata <= '0;
    else if (state == WAIT) rsp_rdata <= mem_rdata;
  end

`ifdef MEM_ARB_ROM_GUARD_EN
  always_ff @(posedge clk) begin
    if (reset)
      rom_wr_err_cnt <= '0;
    else if (rom_wr_err && rom_wr_err_cnt != {ERR_CNT_W{1'b1}})
      rom_wr_err_cnt <= rom_wr_err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter (NUM_REQ=2). Directed scenarios are
// followed by randomized traffic. The traffic is checked against a
// transaction-level model that predicts grant order, the cycle numbers of the
// memory strobes and responses, and read data taken from a shadow memory.
// Inputs are driven 1 time unit after posedge; outputs are sampled 2 units
// after posedge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RB = 256;
`ifdef MEM_ARB_ROM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata, mem_wdata;
  logic [AW-1:0]   mem_address;
  logic            mem_read, mem_write, busy;
  logic [DW-1:0]   mem_rdata = '0;
`ifdef MEM_ARB_ROM_GUARD_EN
  logic            rom_wr_err;
  logic [7:0]      rom_wr_err_cnt;
`endif

  mem_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_BASE(RB)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
`ifdef MEM_ARB_ROM_GUARD_EN
    ,
    .rom_wr_err     (rom_wr_err),
    .rom_wr_err_cnt (rom_wr_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory: synchronous read, ROM region ignores writes.
  logic [DW-1:0] ram    [0:65535];
  logic [DW-1:0] shadow [0:65535];
  always @(posedge clk) begin
    if (mem_write && (mem_address < 16'(RB))) ram[mem_address] <= mem_wdata;
    if (mem_read) mem_rdata <= ram[mem_address];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_last;     // index of the last granted requester
  int exp_err_cnt;  // expected ROM-write error count

  logic [N-1:0]  pv, pw;
  logic [AW-1:0] pa [N];
  logic [DW-1:0] pd [N];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req_valid = pv;
    req_write = pw;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = pa[i];
      req_wdata[i*DW +: DW] = pd[i];
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(0, 15));
      1:       return AW'($urandom_range(16'h00F8, 16'h0107));
      2:       return AW'($urandom_range(16'hFFF8, 16'hFFFF));
      default: return AW'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    logic [N*2+2*DW+AW+2:0] obs;
    reset = 1'b1;
    pv = '0; pw = '0;
    drive();
    cyc(); cyc(); #1;
    obs = {req_ready, rsp_valid, rsp_rdata, mem_wdata, mem_address, mem_read, mem_write, busy};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
`ifdef MEM_ARB_ROM_GUARD_EN
    n_cmp++;
    if ({rom_wr_err, rom_wr_err_cnt} !== 9'd0) begin
      n_bad++; $display("FAIL reset_rom_err: got %h want 0", {rom_wr_err, rom_wr_err_cnt});
    end
`endif
    exp_last = N - 1;
    exp_err_cnt = 0;
  endtask

  task automatic test_first_read();
    cyc();
    reset = 1'b0;
    pv = 2'b01; pw = 2'b00; pa[0] = 16'h0000;
    drive(); #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rd0_ready: got %b want 01", req_ready); end
    cyc(); pv = '0; drive(); #1;
    n_cmp++;
    if ({mem_read, mem_write, mem_address} !== {2'b10, 16'h0000}) begin
      n_bad++; $display("FAIL rd0_issue: got rd=%b wr=%b a=%h want rd=1 wr=0 a=0000", mem_read, mem_write, mem_address);
    end
    cyc(); #1;
    n_cmp++;
    if ({mem_read, mem_write, rsp_valid, busy} !== 5'b00001) begin
      n_bad++; $display("FAIL rd0_wait: got %b want 00001", {mem_read, mem_write, rsp_valid, busy});
    end
    cyc(); #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 8'h5A}) begin
      n_bad++; $display("FAIL rd0_resp: got v=%b d=%h want v=01 d=5a", rsp_valid, rsp_rdata);
    end
    cyc(); #1;
    n_cmp++;
    if ({rsp_valid, busy} !== 3'b000) begin
      n_bad++; $display("FAIL rd0_done: got v=%b busy=%b want 00/0", rsp_valid, busy);
    end
    exp_last = 0;
  endtask

  task automatic test_write_read();
    cyc();
    pv = 2'b10; pw = 2'b10; pa[1] = 16'h0010; pd[1] = 8'h3C;
    drive(); #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin n_bad++; $display("FAIL wr1_ready: got %b want 10", req_ready); end
    cyc(); pv = '0; drive(); #1;
    n_cmp++;
    if ({mem_read, mem_write, mem_address, mem_wdata} !== {2'b01, 16'h0010, 8'h3C}) begin
      n_bad++; $display("FAIL wr1_issue: got rd=%b wr=%b a=%h d=%h want 0/1/0010/3c", mem_read, mem_write, mem_address, mem_wdata);
    end
    shadow[16'h0010] = 8'h3C;
    // Next accept is allowed on the edge right after the write's ISSUE cycle.
    cyc(); pv = 2'b10; pw = 2'b00; drive(); #1;
    n_cmp++;
    if ({req_ready, busy, mem_write} !== 4'b1000) begin
      n_bad++; $display("FAIL rd1_ready: got %b want 1000", {req_ready, busy, mem_write});
    end
    cyc(); pv = '0; drive(); cyc(); cyc(); #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b10, 8'h3C}) begin
      n_bad++; $display("FAIL rd1_resp: got v=%b d=%h want v=10 d=3c", rsp_valid, rsp_rdata);
    end
    exp_last = 1;
  endtask

  task automatic test_no_bubble();
    logic [AW-1:0] a;
    cyc();
    a = AW'($urandom_range(0, 255));
    pv = 2'b10; pw = 2'b00; pa[1] = a;
    drive(); #1;
    n_cmp++;
    if ({req_ready, busy} !== 3'b100) begin
      n_bad++; $display("FAIL nobubble_ready: got %b want 100", {req_ready, busy});
    end
    cyc(); pv = '0; drive(); cyc(); cyc(); #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b10, shadow[a]}) begin
      n_bad++; $display("FAIL nobubble_resp: got v=%b d=%h want v=10 d=%h", rsp_valid, rsp_rdata, shadow[a]);
    end
    exp_last = 1;
  endtask

  // Transaction-level model: the grant goes to the first valid requester after
  // exp_last once the bus is free. A read strobes at +1, responds at +3 and
  // frees at +4. A write strobes at +1 and frees at +2.
  task automatic test_traffic(input int n_tx, input bit all_valid);
    int cyc_n, free_at, rd_at, wr_at, rsp_at, rsp_idx, budget, grants, win, last_win;
    logic [DW-1:0] rsp_data, iss_wdata;
    logic [AW-1:0] iss_addr;
    bit            iss_rom, exp_err;
    logic [N-1:0]  exp_ready, exp_rsp;
    logic [2*N+2:0] obs, exp;
    cyc_n = 0; free_at = 0; rd_at = -1; wr_at = -1; rsp_at = -1; rsp_idx = 0;
    grants = 0; last_win = -1; budget = n_tx * 6 + 40;
    rsp_data = '0; iss_wdata = '0; iss_addr = '0; iss_rom = 1'b0;
    pv = '0;
    while ((grants < n_tx || cyc_n < free_at) && cyc_n < budget) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (i == last_win) pv[i] = 1'b0;
        if (grants >= n_tx) begin
          pv[i] = 1'b0;
        end else if (!pv[i]) begin
          if (all_valid || $urandom_range(0, 1) == 1) begin
            pv[i] = 1'b1;
            pw[i] = all_valid ? 1'b0 : 1'($urandom_range(0, 1));
            pa[i] = rand_addr();
            pd[i] = DW'($urandom);
          end
        end else if (!all_valid && $urandom_range(0, 7) == 0) begin
          pv[i] = 1'b0;
        end
      end
      drive(); #1;

      win = -1;
      if (cyc_n >= free_at)
        for (int k = 1; k <= N; k++)
          if (win < 0 && pv[(exp_last + k) % N]) win = (exp_last + k) % N;
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_rsp = '0;
      if (cyc_n == rsp_at) exp_rsp[rsp_idx] = 1'b1;
      exp_err = GUARD && (cyc_n == wr_at) && iss_rom;
      exp = {exp_ready, cyc_n < free_at, cyc_n == rd_at, (cyc_n == wr_at) && !exp_err, exp_rsp};
      obs = {req_ready, busy, mem_read, mem_write, rsp_valid};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL traffic_ctrl c%0d: got rdy/busy/rd/wr/rsp=%b want %b", cyc_n, obs, exp);
      end
      n_cmp++;
      if ((mem_read && mem_write) || $countones(rsp_valid) > 1) begin
        n_bad++; $display("FAIL traffic_exclusive c%0d: got rd=%b wr=%b rsp=%b want no overlap", cyc_n, mem_read, mem_write, rsp_valid);
      end
      if (cyc_n == rd_at || cyc_n == wr_at) begin
        n_cmp++;
        if (mem_address !== iss_addr || (cyc_n == wr_at && mem_wdata !== iss_wdata)) begin
          n_bad++; $display("FAIL traffic_addr c%0d: got a=%h d=%h want a=%h d=%h", cyc_n, mem_address, mem_wdata, iss_addr, iss_wdata);
        end
      end
      if (cyc_n == rsp_at) begin
        n_cmp++;
        if (rsp_rdata !== rsp_data) begin
          n_bad++; $display("FAIL traffic_rdata c%0d: got %h want %h", cyc_n, rsp_rdata, rsp_data);
        end
      end
`ifdef MEM_ARB_ROM_GUARD_EN
      n_cmp++;
      if ({rom_wr_err, rom_wr_err_cnt} !== {exp_err, 8'(exp_err_cnt)}) begin
        n_bad++; $display("FAIL traffic_rom c%0d: got err=%b cnt=%0d want err=%b cnt=%0d", cyc_n, rom_wr_err, rom_wr_err_cnt, exp_err, exp_err_cnt);
      end
`endif
      if (exp_err && exp_err_cnt < 255) exp_err_cnt++;

      if (win >= 0) begin
        grants++;
        exp_last  = win;
        iss_addr  = pa[win];
        iss_wdata = pd[win];
        iss_rom   = (pa[win] >= 16'(RB));
        if (pw[win]) begin
          wr_at = cyc_n + 1; free_at = cyc_n + 2;
          if (!iss_rom) shadow[pa[win]] = pd[win];
        end else begin
          rd_at = cyc_n + 1; rsp_at = cyc_n + 3; rsp_idx = win;
          rsp_data = shadow[pa[win]]; free_at = cyc_n + 4;
        end
      end
      last_win = win;
      cyc_n++;
    end
    if (cyc_n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL traffic_timeout: got %0d grants want %0d within %0d cycles", grants, n_tx, budget);
    end
    pv = '0; drive();
  endtask

  task automatic test_reset_mid_read();
    cyc();
    pv = 2'b01; pw = 2'b00; pa[0] = 16'h0001;
    drive(); #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_ready: got %b want 01", req_ready); end
    cyc(); pv = '0; drive(); #1;
    n_cmp++;
    if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rst_issue: got rd=%b want 1", mem_read); end
    cyc(); reset = 1'b1; #1;
    n_cmp++;
    if ({busy, rsp_valid} !== 3'b100) begin
      n_bad++; $display("FAIL rst_wait: got busy/rsp=%b want 100", {busy, rsp_valid});
    end
    cyc(); reset = 1'b0; #1;
    n_cmp++;
    if ({busy, mem_read, mem_write, rsp_valid} !== 5'b00000) begin
      n_bad++; $display("FAIL rst_idle: got %b want 00000", {busy, mem_read, mem_write, rsp_valid});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_cmp++;
      if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_no_rsp: got %b want 00", rsp_valid); end
    end
    exp_err_cnt = 0;
    cyc();
    pv = 2'b11; pw = 2'b00; pa[0] = 16'h0002; pa[1] = 16'h0003;
    drive(); #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_prio: got %b want 01", req_ready); end
    cyc(); pv = '0; drive(); cyc(); cyc(); #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, shadow[2]}) begin
      n_bad++; $display("FAIL rst_resp: got v=%b d=%h want v=01 d=%h", rsp_valid, rsp_rdata, shadow[2]);
    end
    exp_last = 0;
  endtask

  task automatic test_rom_write();
    cyc();
    pv = 2'b01; pw = 2'b01; pa[0] = 16'h0100; pd[0] = 8'hFF;
    drive(); #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rom_ready: got %b want 01", req_ready); end
    cyc(); pv = '0; drive(); #1;
    n_cmp++;
    if (mem_address !== 16'h0100) begin n_bad++; $display("FAIL rom_addr: got %h want 0100", mem_address); end
`ifdef MEM_ARB_ROM_GUARD_EN
    n_cmp++;
    if ({mem_write, rom_wr_err, rom_wr_err_cnt} !== {2'b01, 8'd0}) begin
      n_bad++; $display("FAIL rom_guard_issue: got wr=%b err=%b cnt=%0d want 0/1/0", mem_write, rom_wr_err, rom_wr_err_cnt);
    end
    cyc(); #1;
    n_cmp++;
    if ({mem_write, rom_wr_err, rom_wr_err_cnt} !== {2'b00, 8'd1}) begin
      n_bad++; $display("FAIL rom_guard_after: got wr=%b err=%b cnt=%0d want 0/0/1", mem_write, rom_wr_err, rom_wr_err_cnt);
    end
    exp_err_cnt = 1;
`else
    n_cmp++;
    if ({mem_write, mem_wdata} !== {1'b1, 8'hFF}) begin
      n_bad++; $display("FAIL rom_write_issue: got wr=%b d=%h want 1/ff", mem_write, mem_wdata);
    end
    cyc(); #1;
    n_cmp++;
    if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rom_write_after: got wr=%b want 0", mem_write); end
`endif
    cyc(); pv = 2'b01; pw = 2'b00; drive(); #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rom_rd_ready: got %b want 01", req_ready); end
    cyc(); pv = '0; drive(); cyc(); cyc(); #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, shadow[16'h0100]}) begin
      n_bad++; $display("FAIL rom_readback: got v=%b d=%h want v=01 d=%h", rsp_valid, rsp_rdata, shadow[16'h0100]);
    end
    exp_last = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = DW'($urandom);
      shadow[i] = ram[i];
    end
    ram[0] = 8'h5A; shadow[0] = 8'h5A;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
    pv = '0; pw = '0;
    test_reset();
    test_first_read();
    test_write_read();
    test_no_bubble();
    test_traffic(8, 1'b1);
    test_reset_mid_read();
    test_rom_write();
    test_traffic(60, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
